rx_packet: RTL and testbench

RX_PACKET -- requirements
Module: rx_packet

---
 rtl/rx_packet_if.sv | 29 ++
 rtl/rx_packet.sv | 172 +++++++++++++++++
 tb/tb_rx_packet.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_packet_if.sv
// Byte stream from the line decoder into the packet receiver, plus the decoded packet results.
// The master drives the line-side signals. The slave (rx_packet) drives the rx_packet_* results.
interface rx_packet_if;
    logic [7:0]  rx_byte;
    logic        rx_byte_en;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;

    logic [3:0]  rx_packet_pid;
    logic        rx_packet_pid_valid;
    logic [10:0] rx_packet_addr;
    logic [7:0]  rx_packet_byte;
    logic        rx_packet_byte_en;
    logic        rx_packet_fin;
    logic        rx_packet_valid;

    modport master (
        output rx_byte, rx_byte_en, rx_sop, rx_eop, rx_err,
        input  rx_packet_pid, rx_packet_pid_valid, rx_packet_addr,
        input  rx_packet_byte, rx_packet_byte_en, rx_packet_fin, rx_packet_valid
    );

    modport slave (
        input  rx_byte, rx_byte_en, rx_sop, rx_eop, rx_err,
        output rx_packet_pid, rx_packet_pid_valid, rx_packet_addr,
        output rx_packet_byte, rx_packet_byte_en, rx_packet_fin, rx_packet_valid
    );
endinterface

// File: rtl/rx_packet.sv
// USB packet receiver: checks the PID, decodes tokens (CRC5) and data payloads (CRC16), and passes payload bytes through.
// All outputs are registered one cycle after their input. There is no backpressure: bytes arrive at line rate.
module rx_packet (
    input  logic       clk,
    input  logic       rst,
    rx_packet_if.slave bus
);

    typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HSK, DISCARD} state_t;

    localparam logic [4:0]  CRC5_INIT  = 5'h1f;
    localparam logic [4:0]  CRC5_RES   = 5'b01100;
    localparam logic [4:0]  CRC5_POLY  = 5'b00101;
    localparam logic [15:0] CRC16_INIT = 16'hffff;
    localparam logic [15:0] CRC16_RES  = 16'h800d;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [10:0] MAX_BYTES  = 11'd1025;

    state_t      state;
    logic [10:0] cnt;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [7:0]  hold0;
    logic [7:0]  hold1;
    logic [7:0]  tok_lo;
    logic [2:0]  tok_hi;

    logic [3:0]  pid_q;
    logic        pid_vld_q;
    logic [10:0] addr_q;
    logic [7:0]  byte_q;
    logic        byte_en_q;
    logic        fin_q;
    logic        valid_q;

    logic        pid_ok;
    logic        pkt_ok;

    // Both CRCs shift the register toward its MSB, taking the wire bits LSB-first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ CRC5_POLY;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC16_POLY;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // End-of-packet verdict for the state the packet is in when eop arrives.
    always_comb begin
        pid_ok = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]);
        pkt_ok = 1'b0;
        case (state)
            TOKEN:   pkt_ok = (cnt == 11'd2) && (crc5 == CRC5_RES);
            DATA:    pkt_ok = (cnt >= 11'd2) && (crc16 == CRC16_RES);
            HSK:     pkt_ok = 1'b1;
            default: pkt_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            crc5      <= CRC5_INIT;
            crc16     <= CRC16_INIT;
            hold0     <= '0;
            hold1     <= '0;
            tok_lo    <= '0;
            tok_hi    <= '0;
            pid_q     <= '0;
            pid_vld_q <= 1'b0;
            addr_q    <= '0;
            byte_q    <= '0;
            byte_en_q <= 1'b0;
            fin_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            pid_vld_q <= 1'b0;
            byte_en_q <= 1'b0;
            byte_q    <= '0;
            fin_q     <= 1'b0;
            valid_q   <= 1'b0;

            // A new sop always wins: any unfinished packet is dropped without a fin.
            if (bus.rx_sop) begin
                state  <= PID;
                cnt    <= '0;
                crc5   <= CRC5_INIT;
                crc16  <= CRC16_INIT;
                hold0  <= '0;
                hold1  <= '0;
                tok_lo <= '0;
                tok_hi <= '0;
            end else if (state != IDLE) begin
                if (bus.rx_eop) begin
                    fin_q   <= 1'b1;
                    valid_q <= pkt_ok && !bus.rx_err;
                    if (state == TOKEN && pkt_ok && !bus.rx_err)
                        addr_q <= {tok_hi, tok_lo};
                    state   <= IDLE;
                end else if (bus.rx_err) begin
                    state <= DISCARD;
                end else if (bus.rx_byte_en) begin
                    case (state)
                        PID: begin
                            if (!pid_ok) begin
                                state <= DISCARD;
                            end else begin
                                pid_q     <= bus.rx_byte[3:0];
                                pid_vld_q <= 1'b1;
                                case (bus.rx_byte[1:0])
                                    2'b01:   state <= TOKEN;
                                    2'b11:   state <= DATA;
                                    2'b10:   state <= HSK;
                                    default: state <= DISCARD;
                                endcase
                            end
                        end
                        TOKEN: begin
                            if (cnt >= 11'd2) begin
                                state <= DISCARD;
                            end else begin
                                if (cnt == 11'd0) tok_lo <= bus.rx_byte;
                                else              tok_hi <= bus.rx_byte[2:0];
                                crc5 <= crc5_byte(crc5, bus.rx_byte);
                                cnt  <= cnt + 11'd1;
                            end
                        end
                        DATA: begin
                            if (cnt == MAX_BYTES) begin
                                state <= DISCARD;
                            end else begin
                                crc16 <= crc16_byte(crc16, bus.rx_byte);
                                cnt   <= cnt + 11'd1;
                                hold0 <= bus.rx_byte;
                                hold1 <= hold0;
                                // Two bytes are always held back, so the CRC bytes are never emitted.
                                if (cnt >= 11'd2) begin
                                    byte_en_q <= 1'b1;
                                    byte_q    <= hold1;
                                end
                            end
                        end
                        HSK:     state <= DISCARD;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.rx_packet_pid       = pid_q;
    assign bus.rx_packet_pid_valid = pid_vld_q;
    assign bus.rx_packet_addr      = addr_q;
    assign bus.rx_packet_byte      = byte_q;
    assign bus.rx_packet_byte_en   = byte_en_q;
    assign bus.rx_packet_fin       = fin_q;
    assign bus.rx_packet_valid     = valid_q;

endmodule

// File: tb/tb_rx_packet.sv
// Scoreboard bench for rx_packet: expected PIDs, payload bytes and fin results are queued at stimulus time.
module tb_rx_packet;

    logic clk;
    logic rst;

    rx_packet_if bus ();

    rx_packet dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [10:0] addr;
    } fin_t;

    logic [7:0]  exp_byte[$];
    logic [3:0]  exp_pid[$];
    fin_t        exp_fin[$];
    logic [7:0]  pkt[$];
    logic [10:0] cur_addr;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [7:0] setup_v [11] = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00,
                                 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every cycle outside reset, each output event is matched against the queues.
    always @(negedge clk) begin
        fin_t f;
        if (rst === 1'b0) begin
            if (bus.rx_packet_pid_valid) begin
                if (exp_pid.size() == 0) check("pid_unexpected", 32'(bus.rx_packet_pid_valid), 32'd0);
                else check("pid", 32'(bus.rx_packet_pid), 32'(exp_pid.pop_front()));
            end
            if (bus.rx_packet_byte_en) begin
                if (exp_byte.size() == 0) check("byte_unexpected", 32'(bus.rx_packet_byte_en), 32'd0);
                else check("byte", 32'(bus.rx_packet_byte), 32'(exp_byte.pop_front()));
            end else begin
                check("byte_zero", 32'(bus.rx_packet_byte), 32'd0);
            end
            if (bus.rx_packet_fin) begin
                if (exp_fin.size() == 0) begin
                    check("fin_unexpected", 32'(bus.rx_packet_fin), 32'd0);
                end else begin
                    f = exp_fin.pop_front();
                    check("fin_valid", 32'(bus.rx_packet_valid), 32'(f.vld));
                    check("fin_addr", 32'(bus.rx_packet_addr), 32'(f.addr));
                end
            end else begin
                check("valid_no_fin", 32'(bus.rx_packet_valid), 32'd0);
            end
        end
    end

    task automatic drive(input logic sop, input logic be, input logic [7:0] b,
                         input logic eop, input logic err);
        @(posedge clk);
        #1;
        bus.rx_sop     = sop;
        bus.rx_byte_en = be;
        bus.rx_byte    = be ? b : 8'h00;
        bus.rx_eop     = eop;
        bus.rx_err     = err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input int gap);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        foreach (pkt[i]) begin
            drive(1'b0, 1'b1, pkt[i], 1'b0, 1'b0);
            if (gap > 0) idle(int'($urandom_range(0, gap)));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic drain(input string tag);
        idle(3);
        check({tag, "_pid_left"},  32'(exp_pid.size()),  32'd0);
        check({tag, "_byte_left"}, 32'(exp_byte.size()), 32'd0);
        check({tag, "_fin_left"},  32'(exp_fin.size()),  32'd0);
    endtask

    task automatic push_fin(input logic v, input logic [10:0] a);
        fin_t f;
        f.vld  = v;
        f.addr = a;
        exp_fin.push_back(f);
    endtask

    function automatic logic [4:0] m_crc5(input logic [10:0] v);
        logic [4:0] r;
        logic       fb;
        r = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            fb = r[4] ^ v[i];
            r  = {r[3:0], 1'b0};
            if (fb) r = r ^ 5'h05;
        end
        return r;
    endfunction

    function automatic logic [15:0] m_crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    // The CRC field goes on the wire inverted, MSB first. Set bad to corrupt one CRC bit.
    task automatic mk_token(input logic [7:0] pid, input logic [10:0] v, input bit bad);
        logic [4:0] r;
        logic [7:0] b2;
        r  = m_crc5(v);
        b2 = {5'b00000, v[10:8]};
        for (int i = 0; i < 5; i++) b2[3+i] = ~r[4-i];
        if (bad) b2[7] = ~b2[7];
        pkt.delete();
        pkt.push_back(pid);
        pkt.push_back(v[7:0]);
        pkt.push_back(b2);
    endtask

    task automatic mk_data(input logic [7:0] pid, input int n, input int n_exp, input bit bad);
        logic [15:0] r;
        logic [7:0]  b;
        logic [7:0]  c1;
        logic [7:0]  c2;
        r = 16'hffff;
        pkt.delete();
        pkt.push_back(pid);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            pkt.push_back(b);
            if (i < n_exp) exp_byte.push_back(b);
            r = m_crc16(r, b);
        end
        for (int i = 0; i < 8; i++) begin
            c1[i] = ~r[15-i];
            c2[i] = ~r[7-i];
        end
        if (bad) c2[0] = ~c2[0];
        pkt.push_back(c1);
        pkt.push_back(c2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.rx_sop     = 1'b0;
        bus.rx_byte_en = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.rx_eop     = 1'b0;
        bus.rx_err     = 1'b0;
        cur_addr       = 11'h000;
        repeat (2) @(negedge clk);
        check("rst_pid",       32'(bus.rx_packet_pid),       32'd0);
        check("rst_pid_valid", 32'(bus.rx_packet_pid_valid), 32'd0);
        check("rst_addr",      32'(bus.rx_packet_addr),      32'd0);
        check("rst_byte",      32'(bus.rx_packet_byte),      32'd0);
        check("rst_byte_en",   32'(bus.rx_packet_byte_en),   32'd0);
        check("rst_fin",       32'(bus.rx_packet_fin),       32'd0);
        check("rst_valid",     32'(bus.rx_packet_valid),     32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // SETUP token to address 0, endpoint 0.
        pkt.delete();
        pkt.push_back(8'h2D); pkt.push_back(8'h00); pkt.push_back(8'h10);
        exp_pid.push_back(4'hD); push_fin(1'b1, 11'h000);
        send(0); drain("setup_tok");

        // SETUP payload with good and corrupted CRC.
        for (int k = 0; k < 2; k++) begin
            pkt.delete();
            for (int i = 0; i < 11; i++) pkt.push_back(setup_v[i]);
            if (k == 1) pkt[10] = 8'h95;
            exp_pid.push_back(4'h3);
            for (int i = 1; i < 9; i++) exp_byte.push_back(setup_v[i]);
            push_fin(k == 0, 11'h000);
            send(0); drain(k == 0 ? "data0_good" : "data0_bad");
        end

        // IN token to endpoint 3, address 0x15.
        cur_addr = {4'h3, 7'h15};
        mk_token(8'h69, cur_addr, 1'b0);
        exp_pid.push_back(4'h9); push_fin(1'b1, cur_addr);
        send(0); drain("in_tok");

        // DATA1 with random payload and idle gaps; the address must hold.
        mk_data(8'h4B, 5, 5, 1'b0);
        exp_pid.push_back(4'hB); push_fin(1'b1, cur_addr);
        send(2); drain("data1_gaps");

        // Zero-byte payload is legal. A single byte after the PID is not.
        mk_data(8'hC3, 0, 0, 1'b0);
        exp_pid.push_back(4'h3); push_fin(1'b1, cur_addr);
        send(0); drain("data_empty");
        pkt.delete(); pkt.push_back(8'hC3); pkt.push_back(8'h00);
        exp_pid.push_back(4'h3); push_fin(1'b0, cur_addr);
        send(0); drain("data_short");

        // ACK alone is valid. ACK followed by a byte is not.
        pkt.delete(); pkt.push_back(8'hD2);
        exp_pid.push_back(4'h2); push_fin(1'b1, cur_addr);
        send(0); drain("ack");
        pkt.push_back(8'h00);
        exp_pid.push_back(4'h2); push_fin(1'b0, cur_addr);
        send(0); drain("ack_extra");

        // Bad PID check.
        pkt.delete(); pkt.push_back(8'h2C);
        push_fin(1'b0, cur_addr);
        send(0); drain("bad_pid");

        // Token with a bad CRC5 and a 3-byte token leave the address unchanged.
        mk_token(8'h69, 11'h2AA, 1'b1);
        exp_pid.push_back(4'h9); push_fin(1'b0, cur_addr);
        send(0); drain("tok_bad_crc");
        mk_token(8'h2D, 11'h000, 1'b0);
        pkt.push_back(8'h00);
        exp_pid.push_back(4'hD); push_fin(1'b0, cur_addr);
        send(0); drain("tok_long");

        // Line error after the third payload byte.
        exp_pid.push_back(4'h3); exp_byte.push_back(8'h80); push_fin(1'b0, cur_addr);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, setup_v[i], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 4; i < 11; i++) drive(1'b0, 1'b1, setup_v[i], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drain("rx_err");

        // eop in IDLE produces nothing. A second sop silently aborts the first packet.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drain("idle_eop");
        exp_pid.push_back(4'h3); exp_pid.push_back(4'hD); push_fin(1'b1, 11'h000);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
        pkt.delete(); pkt.push_back(8'h2D); pkt.push_back(8'h00); pkt.push_back(8'h10);
        send(0); drain("sop_abort");
        cur_addr = 11'h000;

        // Length limits: 1025 bytes after the PID is valid. 1026 bytes is discarded.
        mk_data(8'hC3, 1023, 1023, 1'b0);
        exp_pid.push_back(4'h3); push_fin(1'b1, cur_addr);
        send(0); drain("len_max");
        mk_data(8'hC3, 1024, 1023, 1'b0);
        exp_pid.push_back(4'h3); push_fin(1'b0, cur_addr);
        send(0); drain("len_over");

        // Reset in the middle of a data packet.
        exp_pid.push_back(4'h3); exp_byte.push_back(8'h80); exp_byte.push_back(8'h06);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, setup_v[i], 1'b0, 1'b0);
        idle(1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_byte_en", 32'(bus.rx_packet_byte_en),   32'd0);
        check("mid_rst_byte",    32'(bus.rx_packet_byte),      32'd0);
        check("mid_rst_pid",     32'(bus.rx_packet_pid),       32'd0);
        check("mid_rst_pid_vld", 32'(bus.rx_packet_pid_valid), 32'd0);
        check("mid_rst_fin",     32'(bus.rx_packet_fin),       32'd0);
        check("mid_rst_valid",   32'(bus.rx_packet_valid),     32'd0);
        idle(2);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 1'b1, 8'h2D, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drain("post_rst_ignore");
        check("post_rst_addr", 32'(bus.rx_packet_addr), 32'd0);
        pkt.delete(); pkt.push_back(8'h2D); pkt.push_back(8'h00); pkt.push_back(8'h10);
        exp_pid.push_back(4'hD); push_fin(1'b1, 11'h000);
        send(0); drain("post_rst_tok");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
